seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the combinational ALU, sitting in the execute stage.
- Single-cycle ops (add, sub, and, or) finish one cycle after issue.
- Multiply (shift-add) and divide (restoring) run iteratively over WIDTH cycles, with a start/busy/done handshake the pipeline stalls on.
- Adds a registered overflow flag, a divide-by-zero flag and an illegal-opcode flag.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue pulse; operands/ctrl sampled when start=1 and busy=0.
- ctrl  in  4  opcode: 1 ADD, 2 SUB, 4 MUL, 8 DIV, C AND, E OR, F ADD (no-func).
- in1  in  WIDTH  operand A (unsigned for MUL/DIV, two's complement for overflow check).
- in2  in  WIDTH  operand B.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; out/r0/flags are valid from this cycle.
- out  out  WIDTH  result; MUL low half; DIV quotient.
- r0  out  WIDTH  MUL high half; DIV remainder; unchanged by other ops.
- overflow_flag  out  1  signed overflow of ADD/SUB; 0 for other ops.
- div_zero  out  1  DIV issued with in2=0.
- illegal_op  out  1  ctrl not in the opcode list.

Behaviour:
- Reset: asynchronous, active-low; drives every output and all internal state to 0 and the FSM to IDLE.
- Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: in IDLE with start=1, latch in1, in2 and ctrl. start while busy=1 is ignored; no queuing.
- Single-cycle ops:
  - Go IDLE->DONE.
  - out is registered and done pulses on the cycle after accept (latency 1). busy stays 0 for these ops.
  - ADD: out=(in1+in2) mod 2^WIDTH; overflow_flag = operand signs equal and result sign differs.
  - SUB: out=in1-in2; overflow_flag = operand signs differ and result sign differs from in1.
  - AND/OR: bitwise; overflow_flag=0.
- MUL:
  - IDLE->MUL; counter loads WIDTH.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the 2*WIDTH accumulator; then shift right.
  - counter reaches 0 -> DONE. done pulses WIDTH+1 cycles after accept.
  - {r0,out} = full 2*WIDTH unsigned product.
- DIV:
  - in2=0: skip iteration and go IDLE->DONE with latency 1; out=all ones, r0=in1, div_zero=1.
  - Otherwise IDLE->DIV: WIDTH restoring iterations (shift remainder, trial subtract, restore on negative), then DONE. Latency WIDTH+1.
  - out=quotient, r0=remainder.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Illegal ctrl (0,3,5,6,7,9,A,B,D):
  - Latency 1; done pulses; illegal_op=1.
  - out and r0 hold their previous values (successor to the old hold-on-default behaviour).
- Flags: overflow_flag, div_zero and illegal_op update only on done and hold until the next done.
- Holding rules: r0 changes only on MUL or DIV completion; out changes only on done.
- Edge cases:
  - WIDTH-bit wrap-around is silent except via overflow_flag.
  - Largest MUL product (all-ones × all-ones) must be exact.

Optional Feature:
FAST_MUL_EN
- Defined: MUL uses one combinational multiplier and completes with latency 1 (IDLE->DONE, busy stays 0). Results are identical.
- Undefined: iterative shift-add multiply with latency WIDTH+1; no multiplier inferred.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_ADDNF.
  - FSM state typedef alu_state_t {IDLE, MUL, DIV, DONE}.
  - Function is_legal_op(ctrl).
- One natural sub-module: alu_iter_unit.
  - Owns the 2*WIDTH accumulator, iteration counter and shift-add/restoring step; mode input selects mul or div.
  - seq_alu keeps the FSM, the single-cycle datapath, flags and the handshake.

Test Plan (WIDTH=16):
- ADD 0x7FFF+0x0001 -> done 1 cycle after accept, out=0x8000, overflow_flag=1. SUB 0x0005-0x0007 -> out=0xFFFE, overflow_flag=0.
- MUL 0xFFFF*0xFFFF -> busy for 16 cycles, done at cycle 17, r0=0xFFFE, out=0x0001. With FAST_MUL_EN defined, same result at latency 1.
- DIV 100/7 -> done at cycle 17, out=0x000E, r0=0x0002. DIV 0x1234/0 -> latency 1, out=0xFFFF, r0=0x1234, div_zero=1.
- start pulsed with a different operand pair during a MUL -> ignored; the result matches the first op; exactly one done pulse.
- rst_n low at iteration 8 of a DIV -> all outputs 0 immediately, no done pulse. A fresh ADD 2+3 after release -> out=0x0005.
- ctrl=4'hD with prior out=0x0005 -> done at latency 1, illegal_op=1, out holds 0x0005, r0 unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state type and opcode legality helper for seq_alu
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_DIV   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'hC;
    localparam logic [3:0] OP_OR    = 4'hE;
    localparam logic [3:0] OP_ADDNF = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_ADDNF);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - issue/result bundle between the execute stage and seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] r0;
    logic             overflow_flag;
    logic             div_zero;
    logic             illegal_op;

    modport master (
        output start, ctrl, in1, in2,
        input  busy, done, out, r0, overflow_flag, div_zero, illegal_op
    );

    modport slave (
        input  start, ctrl, in1, in2,
        output busy, done, out, r0, overflow_flag, div_zero, illegal_op
    );
endinterface

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - shared shift-add multiply / restoring divide iteration engine
module alu_iter_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc[2W:W] is the running high part (mul) or partial remainder (div);
    // acc[W-1:0] shifts out multiplier bits / dividend bits and shifts in product / quotient bits.
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_next;
    logic [WIDTH-1:0] opnd;
    logic             div_mode_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;

    // One iteration step for the latched mode
    always_comb begin
        mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        trial     = {1'b0, rem_shift} - {2'b00, opnd};
        if (div_mode_q) begin
            if (trial[WIDTH+1])
                acc_next = {rem_shift, acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Load operands on issue, then advance one step per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            opnd       <= '0;
            div_mode_q <= 1'b0;
            cnt        <= '0;
        end else if (load) begin
            acc        <= {{(WIDTH+1){1'b0}}, (mode_div ? op_a : op_b)};
            opnd       <= mode_div ? op_b : op_a;
            div_mode_q <= mode_div;
            cnt        <= CNT_W'(WIDTH);
        end else if (step) begin
            acc        <= acc_next;
            cnt        <= cnt - 1'b1;
        end
    end

    // Results are the post-step values so the caller can register them on the final step
    assign last   = (cnt == CNT_W'(1));
    assign res_hi = acc_next[2*WIDTH-1:WIDTH];
    assign res_lo = acc_next[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered execute-stage ALU with iterative mul/div (FAST_MUL_EN: single-cycle multiply)
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    import alu_pkg::*;

    alu_state_t       state;
    alu_state_t       state_next;
    logic             accept;
    logic             running;
    logic             iter_load;
    logic             iter_div;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;

    assign accept   = (state == IDLE) && bus.start;
    assign running  = (state == MUL) || (state == DIV);
    assign iter_div = (bus.ctrl == OP_DIV);
    assign add_res  = bus.in1 + bus.in2;
    assign sub_res  = bus.in1 - bus.in2;

`ifdef FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, bus.in1} * {{WIDTH{1'b0}}, bus.in2};
    assign iter_load = accept && iter_div && (bus.in2 != '0);
`else
    assign iter_load = accept && ((bus.ctrl == OP_MUL) || (iter_div && (bus.in2 != '0)));
`endif

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (iter_load),
        .mode_div (iter_div),
        .op_a     (bus.in1),
        .op_b     (bus.in2),
        .step     (running),
        .last     (iter_last),
        .res_hi   (iter_hi),
        .res_lo   (iter_lo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: iterative ops go through MUL/DIV, everything else straight to DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (iter_load) state_next = iter_div ? DIV : MUL;
                    else           state_next = DONE;
                end
            end
            MUL, DIV: if (iter_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.busy = running;
        bus.done = (state == DONE);
    end

    // Result and flag registers: load only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out           <= '0;
            bus.r0            <= '0;
            bus.overflow_flag <= 1'b0;
            bus.div_zero      <= 1'b0;
            bus.illegal_op    <= 1'b0;
        end else if (accept && !iter_load) begin
            bus.overflow_flag <= 1'b0;
            bus.div_zero      <= 1'b0;
            bus.illegal_op    <= !is_legal_op(bus.ctrl);
            case (bus.ctrl)
                OP_ADD: begin
                    bus.out           <= add_res;
                    bus.overflow_flag <= (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                                         (add_res[WIDTH-1] != bus.in1[WIDTH-1]);
                end
                OP_ADDNF: bus.out <= add_res;
                OP_SUB: begin
                    bus.out           <= sub_res;
                    bus.overflow_flag <= (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                                         (sub_res[WIDTH-1] != bus.in1[WIDTH-1]);
                end
                OP_AND: bus.out <= bus.in1 & bus.in2;
                OP_OR:  bus.out <= bus.in1 | bus.in2;
`ifdef FAST_MUL_EN
                OP_MUL: {bus.r0, bus.out} <= fast_prod;
`endif
                OP_DIV: begin
                    bus.out      <= '1;
                    bus.r0       <= bus.in1;
                    bus.div_zero <= 1'b1;
                end
                default: ;
            endcase
        end else if (running && iter_last) begin
            bus.out           <= iter_lo;
            bus.r0            <= iter_hi;
            bus.overflow_flag <= 1'b0;
            bus.div_zero      <= 1'b0;
            bus.illegal_op    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with a behavioural result model
module tb_seq_alu;
    localparam int W = 16;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_cnt = 0;
    bit          m_done = 0, was_done = 0;
    logic [15:0] m_out = '0, m_r0 = '0, p_out = '0, p_r0 = '0;
    bit          m_ovf = 0, m_dz = 0, m_il = 0, p_ovf = 0, p_dz = 0, p_il = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        longint unsigned prod;
        int lat;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p_out = m_out; p_r0 = m_r0; p_ovf = 0; p_dz = 0; p_il = 0; lat = 1;
        case (c)
            4'h1: begin r = sa + sb; p_out = a + b; p_ovf = (r > 32767) || (r < -32768); end
            4'hF: p_out = a + b;
            4'h2: begin r = sa - sb; p_out = a - b; p_ovf = (r > 32767) || (r < -32768); end
            4'hC: p_out = a & b;
            4'hE: p_out = a | b;
            4'h4: begin
                prod = longint'(a) * longint'(b);
                p_out = prod[15:0]; p_r0 = prod[31:16]; lat = MUL_LAT;
            end
            4'h8: begin
                if (b == 0) begin p_out = 16'hFFFF; p_r0 = a; p_dz = 1; end
                else begin p_out = a / b; p_r0 = a % b; lat = W + 1; end
            end
            default: p_il = 1;
        endcase
        m_cnt = lat - 1;
    endtask

    task automatic model_finish();
        m_out = p_out; m_r0 = p_r0; m_ovf = p_ovf; m_dz = p_dz; m_il = p_il; m_done = 1;
    endtask

    // Model advances on the same edges as the DUT, from the bench's own stimulus
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_done = 0; m_out = '0; m_r0 = '0; m_ovf = 0; m_dz = 0; m_il = 0;
        end else begin
            was_done = m_done;
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) model_finish();
            end else if (!was_done && bus.start) begin
                model_issue(bus.ctrl, bus.in1, bus.in2);
                if (m_cnt == 0) model_finish();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", 32'(bus.busy), 32'(m_cnt > 0));
            cmp("done", 32'(bus.done), 32'(m_done));
            cmp("out", 32'(bus.out), 32'(m_out));
            cmp("r0", 32'(bus.r0), 32'(m_r0));
            cmp("ovf", 32'(bus.overflow_flag), 32'(m_ovf));
            cmp("div_zero", 32'(bus.div_zero), 32'(m_dz));
            cmp("illegal", 32'(bus.illegal_op), 32'(m_il));
        end
    end

    task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = c; bus.in1 = a; bus.in2 = b;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            miscompares++; vectors++;
            $display("FAIL timeout: ctrl %h no done within 100 cycles", c);
        end
    endtask

    task automatic run_check(input string name, input logic [3:0] c, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] eo, input logic [15:0] er,
                             input bit eov, input bit edz, input bit eil, input int elat);
        int lat;
        run_op(c, a, b, lat);
        cmp({name, ".out"}, 32'(bus.out), 32'(eo));
        cmp({name, ".r0"}, 32'(bus.r0), 32'(er));
        cmp({name, ".ovf"}, 32'(bus.overflow_flag), 32'(eov));
        cmp({name, ".dz"}, 32'(bus.div_zero), 32'(edz));
        cmp({name, ".il"}, 32'(bus.illegal_op), 32'(eil));
        cmp({name, ".lat"}, 32'(lat), 32'(elat));
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    int          dones;
    logic [3:0]  first_op;
    logic [15:0] first_a, first_b, first_out, first_r0;

    initial begin
        bus.start = 1'b0; bus.ctrl = '0; bus.in1 = '0; bus.in2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        cmp("rst.busy", 32'(bus.busy), 0);
        cmp("rst.done", 32'(bus.done), 0);
        cmp("rst.out", 32'(bus.out), 0);
        cmp("rst.r0", 32'(bus.r0), 0);

        run_check("add_ovf",  4'h1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1, 0, 0, 1);
        run_check("sub_neg",  4'h2, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 0, 0, 0, 1);
        run_check("add_wrap", 4'h1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 0, 0, 1);
        run_check("sub_ovf",  4'h2, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1, 0, 0, 1);
        run_check("and",      4'hC, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 0, 0, 0, 1);
        run_check("or",       4'hE, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000, 0, 0, 0, 1);
        run_check("addnf",    4'hF, 16'h1000, 16'h0234, 16'h1234, 16'h0000, 0, 0, 0, 1);
        run_check("mul_max",  4'h4, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, MUL_LAT);
        run_check("div",      4'h8, 16'd100,  16'd7,    16'h000E, 16'h0002, 0, 0, 0, W + 1);
        run_check("div0",     4'h8, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 0, 1, 0, 1);
        run_check("ill3",     4'h3, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h1234, 0, 0, 1, 1);
        run_check("mul_mid",  4'h4, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 0, 0, 0, MUL_LAT);
        run_check("div_one",  4'h8, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, W + 1);
        run_check("div_small",4'h8, 16'h0003, 16'h0010, 16'h0000, 16'h0003, 0, 0, 0, W + 1);

        // start during busy is ignored: exactly one done with the first op's result
`ifdef FAST_MUL_EN
        first_op = 4'h8; first_a = 16'd100; first_b = 16'd7; first_out = 16'h000E; first_r0 = 16'h0002;
`else
        first_op = 4'h4; first_a = 16'd3; first_b = 16'd5; first_out = 16'h000F; first_r0 = 16'h0000;
`endif
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = first_op; bus.in1 = first_a; bus.in2 = first_b;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.ctrl = 4'h8; bus.in1 = 16'd9; bus.in2 = 16'd2;
        @(negedge clk); bus.start = 1'b0;
        count_dones(30, dones);
        cmp("ignore.dones", 32'(dones), 1);
        cmp("ignore.out", 32'(bus.out), 32'(first_out));
        cmp("ignore.r0", 32'(bus.r0), 32'(first_r0));

        // start held in the DONE cycle is ignored
        run_check("add11", 4'h1, 16'h0001, 16'h0001, 16'h0002, first_r0, 0, 0, 0, 1);
        bus.start = 1'b1; bus.ctrl = 4'hE; bus.in1 = 16'hFFFF; bus.in2 = 16'h0000;
        @(negedge clk); bus.start = 1'b0;
        count_dones(4, dones);
        cmp("done_ign.dones", 32'(dones), 0);
        cmp("done_ign.out", 32'(bus.out), 32'h0002);

        // reset in the middle of a divide aborts it
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = 4'h8; bus.in1 = 16'd100; bus.in2 = 16'd7;
        @(negedge clk); bus.start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        cmp("abort.busy", 32'(bus.busy), 0);
        cmp("abort.done", 32'(bus.done), 0);
        cmp("abort.out", 32'(bus.out), 0);
        cmp("abort.r0", 32'(bus.r0), 0);
        count_dones(3, dones);
        @(negedge clk) rst_n = 1'b1;
        count_dones(20, dones);
        cmp("abort.dones", 32'(dones), 0);

        run_check("add23",  4'h1, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 0, 0, 0, 1);
        run_check("illD",   4'hD, 16'h1111, 16'h2222, 16'h0005, 16'h0000, 0, 0, 1, 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
